// File: rtl/loby_sponge_ctrl.sv
// rtl/loby_sponge_ctrl.sv - LoBy sponge core sequencer: one init, N_ABS absorbs, N_SQZ squeezes, result handshake
module loby_sponge_ctrl #(
    parameter int KEY_W = 257,
    parameter int DIN_W = 64,
    parameter int N_ABS = 2,
    parameter int N_SQZ = 2,
    parameter int GAP   = 1
) (
    input  logic             clk,
    input  logic             arstn,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [KEY_W-1:0] cmd_key,
    input  logic             msg_valid,
    output logic             msg_ready,
    input  logic [DIN_W-1:0] msg_data,
    input  logic             abort,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [KEY_W-1:0] out_data,
    output logic             busy,
    output logic             core_init,
    output logic             core_din_valid,
    output logic             core_sqz,
    output logic [DIN_W-1:0] core_din,
    output logic [KEY_W-1:0] core_key,
    input  logic [KEY_W-1:0] core_dout
);

    localparam int N_OPS = N_ABS + N_SQZ;
    localparam int OP_W  = $clog2(N_OPS) + 1;
    localparam int GAP_W = $clog2(GAP) + 1;

    localparam logic [OP_W-1:0]  LAST_OP   = OP_W'(N_OPS - 1);
    localparam logic [OP_W-1:0]  FIRST_SQZ = OP_W'(N_ABS);
    localparam logic [GAP_W-1:0] GAP_LOAD  = GAP_W'(GAP - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_GAP,
        S_WAIT_MSG,
        S_PULSE,
        S_CAPT,
        S_DONE
    } state_t;

    state_t           state;
    logic [OP_W-1:0]  op_idx;
    logic [GAP_W-1:0] gap_cnt;

    // Outputs are registered alongside the state, so every output is set on the
    // same edge that enters the state it belongs to.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state          <= S_IDLE;
            op_idx         <= '0;
            gap_cnt        <= '0;
            cmd_ready      <= 1'b0;
            msg_ready      <= 1'b0;
            out_valid      <= 1'b0;
            out_data       <= '0;
            busy           <= 1'b0;
            core_init      <= 1'b0;
            core_din_valid <= 1'b0;
            core_sqz       <= 1'b0;
            core_din       <= '0;
            core_key       <= '0;
        end else begin
            core_init      <= 1'b0;
            core_din_valid <= 1'b0;
            core_sqz       <= 1'b0;

            if (abort && state != S_IDLE) begin
                state     <= S_IDLE;
                msg_ready <= 1'b0;
                out_valid <= 1'b0;
                busy      <= 1'b0;
                cmd_ready <= 1'b1;
            end else begin
                case (state)
                    S_IDLE: begin
                        cmd_ready <= 1'b1;
                        if (cmd_valid && cmd_ready) begin
                            core_key  <= cmd_key;
                            core_din  <= '0;
                            op_idx    <= '0;
                            gap_cnt   <= GAP_LOAD;
                            core_init <= 1'b1;
                            cmd_ready <= 1'b0;
                            busy      <= 1'b1;
                            state     <= S_INIT;
                        end
                    end
                    S_INIT: begin
                        state <= S_GAP;
                    end
                    S_GAP: begin
                        if (gap_cnt == '0) begin
                            msg_ready <= 1'b1;
                            state     <= S_WAIT_MSG;
                        end else begin
                            gap_cnt <= gap_cnt - 1'b1;
                        end
                    end
                    S_WAIT_MSG: begin
                        if (msg_valid) begin
                            core_din       <= msg_data;
                            core_din_valid <= 1'b1;
                            core_sqz       <= (op_idx >= FIRST_SQZ);
                            msg_ready      <= 1'b0;
                            state          <= S_PULSE;
                        end
                    end
                    S_PULSE: begin
                        op_idx  <= op_idx + 1'b1;
                        gap_cnt <= GAP_LOAD;
                        state   <= (op_idx == LAST_OP) ? S_CAPT : S_GAP;
                    end
                    S_CAPT: begin
                        // Doubles as the gap after the final squeeze; dout is
                        // taken in its first cycle, right after the last sqz.
                        if (gap_cnt == GAP_LOAD) begin
                            out_data <= core_dout;
                        end
                        if (gap_cnt == '0) begin
                            out_valid <= 1'b1;
                            state     <= S_DONE;
                        end else begin
                            gap_cnt <= gap_cnt - 1'b1;
                        end
                    end
                    S_DONE: begin
                        if (out_ready) begin
                            out_valid <= 1'b0;
                            busy      <= 1'b0;
                            cmd_ready <= 1'b1;
                            state     <= S_IDLE;
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_loby_sponge_ctrl.sv
// tb/tb_loby_sponge_ctrl.sv - directed bench for loby_sponge_ctrl with a behavioural LoBy core
module tb_loby_sponge_ctrl;

    logic         clk = 1'b0;
    logic         arstn;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [256:0] cmd_key;
    logic         msg_valid;
    logic         msg_ready;
    logic [63:0]  msg_data;
    logic         abort;
    logic         out_valid;
    logic         out_ready;
    logic [256:0] out_data;
    logic         busy;
    logic         core_init;
    logic         core_din_valid;
    logic         core_sqz;
    logic [63:0]  core_din;
    logic [256:0] core_key;
    logic [256:0] core_dout;

    int n_cmp = 0;
    int n_err = 0;

    logic [63:0]  words [4];
    logic [63:0]  init_m, dv_m, sqz_m;
    int           ov_cyc;
    logic [256:0] od;
    logic [256:0] cs;

    loby_sponge_ctrl dut (
        .clk(clk), .arstn(arstn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_key(cmd_key),
        .msg_valid(msg_valid), .msg_ready(msg_ready), .msg_data(msg_data),
        .abort(abort),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy),
        .core_init(core_init), .core_din_valid(core_din_valid), .core_sqz(core_sqz),
        .core_din(core_din), .core_key(core_key), .core_dout(core_dout)
    );

    always #5 clk = ~clk;

    function automatic logic [256:0] mix(input logic [256:0] s, input logic [63:0] d);
        return {s[255:0], s[256]} ^ {193'd0, d};
    endfunction

    function automatic logic [256:0] ref_dout(input logic [256:0] key);
        logic [256:0] s = key;
        for (int i = 0; i < 4; i++) s = mix(s, words[i]);
        return s;
    endfunction

    // Stand-in LoBy core: dout updates only on squeeze pulses
    always @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            cs        <= '0;
            core_dout <= '0;
        end else if (core_init) begin
            cs <= core_key;
        end else if (core_din_valid) begin
            cs <= mix(cs, core_din);
            if (core_sqz) core_dout <= mix(cs, core_din);
        end
    end

    task automatic chk(input string tag, input logic [256:0] obs, input logic [256:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_txn(input logic [256:0] key, input int stall_idx, input int stall_len,
                           input int hold_len);
        int sent, stall, held;
        bit hs_msg, hs_out, done;
        init_m = '0; dv_m = '0; sqz_m = '0; ov_cyc = -1; od = '0;
        sent = 0; stall = stall_len; held = 0; done = 0;
        chk("cmd_ready_idle", 257'(cmd_ready), 257'd1);
        cmd_key = key;
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        for (int c = 1; c < 64 && !done; c++) begin
            msg_valid = !(sent == stall_idx && stall > 0);
            msg_data  = words[sent % 4];
            out_ready = (held >= hold_len);
            init_m[c] = core_init;
            dv_m[c]   = core_din_valid;
            sqz_m[c]  = core_sqz;
            if (core_din_valid) chk("core_din", 257'(core_din), 257'(words[sent-1]));
            if (out_valid) begin
                if (ov_cyc < 0) begin
                    ov_cyc = c;
                    od     = out_data;
                end else begin
                    chk("hold_out_data", out_data, od);
                end
                chk("done_cmd_ready", 257'(cmd_ready), 257'd0);
            end
            hs_msg = msg_valid && msg_ready;
            hs_out = out_valid && out_ready;
            if (msg_ready && !msg_valid) stall--;
            if (out_valid && !out_ready) held++;
            step();
            if (hs_msg) sent++;
            if (hs_out) begin
                chk("out_valid_drop", 257'(out_valid), 257'd0);
                chk("cmd_ready_after", 257'(cmd_ready), 257'd1);
                chk("busy_after", 257'(busy), 257'd0);
                done = 1;
            end
        end
        chk("txn_completed", 257'(done), 257'd1);
        msg_valid = 1'b0;
        out_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        arstn = 1'b0; cmd_valid = 1'b0; cmd_key = '0; msg_valid = 1'b0;
        msg_data = '0; abort = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cmd_ready", 257'(cmd_ready), 257'd0);
        chk("rst_busy", 257'(busy), 257'd0);
        chk("rst_out_valid", 257'(out_valid), 257'd0);
        chk("rst_core_init", 257'(core_init), 257'd0);
        arstn = 1'b1;
        step();
        chk("post_rst_cmd_ready", 257'(cmd_ready), 257'd1);
        chk("post_rst_busy", 257'(busy), 257'd0);

        // Nominal transaction
        words = '{64'h1, 64'h2, 64'h3, 64'h4};
        run_txn({1'b1, {4{64'hDEAD_BEEF_0123_4567}}}, -1, 0, 0);
        chk("nom_init_mask", 257'(init_m), 257'h2);
        chk("nom_dv_mask", 257'(dv_m), 257'h2490);
        chk("nom_sqz_mask", 257'(sqz_m), 257'h2400);
        chk("nom_ov_cycle", 257'(ov_cyc), 257'd15);
        chk("nom_out_data", od, ref_dout({1'b1, {4{64'hDEAD_BEEF_0123_4567}}}));

        // Stall of 5 cycles before word 2, then out_ready held low 3 cycles
        words = '{64'hAAAA_0000_0000_0001, 64'h5555_0000_0000_0002,
                  64'hFFFF_FFFF_FFFF_FFFF, 64'h0};
        run_txn({1'b0, 256'h1234_5678}, 1, 5, 3);
        chk("stall_init_mask", 257'(init_m), 257'h2);
        chk("stall_dv_mask", 257'(dv_m), 257'h49010);
        chk("stall_sqz_mask", 257'(sqz_m), 257'h48000);
        chk("stall_ov_cycle", 257'(ov_cyc), 257'd20);
        chk("stall_out_data", od, ref_dout({1'b0, 256'h1234_5678}));

        // Back-to-back transactions with distinct keys
        words = '{64'h0123_4567_89AB_CDEF, 64'h1, 64'h8000_0000_0000_0000, 64'h77};
        run_txn({1'b1, 256'h0}, -1, 0, 0);
        chk("b2b1_dv_mask", 257'(dv_m), 257'h2490);
        chk("b2b1_sqz_mask", 257'(sqz_m), 257'h2400);
        chk("b2b1_out_data", od, ref_dout({1'b1, 256'h0}));
        words = '{64'h9, 64'h8, 64'h7, 64'h6};
        run_txn({1'b0, {8{32'hC0FF_EE00}}}, -1, 0, 0);
        chk("b2b2_init_mask", 257'(init_m), 257'h2);
        chk("b2b2_dv_mask", 257'(dv_m), 257'h2490);
        chk("b2b2_ov_cycle", 257'(ov_cyc), 257'd15);
        chk("b2b2_out_data", od, ref_dout({1'b0, {8{32'hC0FF_EE00}}}));

        // Abort in WAIT_MSG after one absorb, colliding with a msg handshake
        cmd_key = {1'b1, 256'hF00D}; cmd_valid = 1'b1;
        msg_valid = 1'b1; msg_data = 64'hA5;
        step();
        cmd_valid = 1'b0;
        step();
        step();
        chk("abt_wait1_msg_ready", 257'(msg_ready), 257'd1);
        step();
        chk("abt_pulse_dv", 257'(core_din_valid), 257'd1);
        chk("abt_pulse_sqz", 257'(core_sqz), 257'd0);
        msg_data = 64'h5A;
        step();
        step();
        chk("abt_wait2_msg_ready", 257'(msg_ready), 257'd1);
        abort = 1'b1;
        step();
        abort = 1'b0; msg_valid = 1'b0;
        chk("abt_busy", 257'(busy), 257'd0);
        chk("abt_cmd_ready", 257'(cmd_ready), 257'd1);
        chk("abt_dv", 257'(core_din_valid), 257'd0);
        chk("abt_msg_ready", 257'(msg_ready), 257'd0);
        chk("abt_out_valid", 257'(out_valid), 257'd0);
        step();
        chk("abt_idle_sqz", 257'(core_sqz), 257'd0);
        chk("abt_idle_out_valid", 257'(out_valid), 257'd0);
        chk("abt_din_held", 257'(core_din), 257'hA5);

        // Abort while idle must not block the new command
        cmd_key = 257'h1; cmd_valid = 1'b1; abort = 1'b1;
        step();
        cmd_valid = 1'b0; abort = 1'b0;
        chk("new_core_init", 257'(core_init), 257'd1);
        chk("new_core_key", core_key, 257'h1);
        chk("new_busy", 257'(busy), 257'd1);

        // Asynchronous reset mid-transaction
        step();
        arstn = 1'b0;
        #1;
        chk("mid_rst_busy", 257'(busy), 257'd0);
        chk("mid_rst_cmd_ready", 257'(cmd_ready), 257'd0);
        chk("mid_rst_core_key", core_key, 257'd0);
        chk("mid_rst_out_data", out_data, 257'd0);
        chk("mid_rst_core_din", 257'(core_din), 257'd0);
        chk("mid_rst_strobes", 257'({core_init, core_din_valid, core_sqz, msg_ready, out_valid}), 257'd0);
        #3;
        arstn = 1'b1;
        step();
        chk("mid_rel_cmd_ready", 257'(cmd_ready), 257'd1);
        chk("mid_rel_busy", 257'(busy), 257'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
